// File: rtl/filter_tile_grid_if.sv
// Video bus between the raster timing source, the tile memories
// and the tile-grid compositor.
interface filter_tile_grid_if #(
  parameter int NUM_TILES   = 6,
  parameter int PIXEL_WIDTH = 12,
  parameter int TILE_W      = 240,
  parameter int TILE_H      = 320
);
  localparam int XW = $clog2(TILE_W);
  localparam int YW = $clog2(TILE_H);

  logic [10:0]                      hcount_in;
  logic [9:0]                       vcount_in;
  logic [NUM_TILES*PIXEL_WIDTH-1:0] tile_pixel_in;
  logic [XW-1:0]                    tile_x_out;
  logic [YW-1:0]                    tile_y_out;
  logic                             tile_hit_out;
  logic [PIXEL_WIDTH-1:0]           pixel_out;

  modport master (
    output hcount_in,
    output vcount_in,
    output tile_pixel_in,
    input  tile_x_out,
    input  tile_y_out,
    input  tile_hit_out,
    input  pixel_out
  );

  modport slave (
    input  hcount_in,
    input  vcount_in,
    input  tile_pixel_in,
    output tile_x_out,
    output tile_y_out,
    output tile_hit_out,
    output pixel_out
  );
endinterface

// File: rtl/filter_tile_grid.sv
// Filter-preview compositor: tile grid, highlight border around the
// selected tile, vblank-committed selection and a lock toggle.
module filter_tile_grid #(
  parameter int NUM_TILES   = 6,
  parameter int COLS        = 3,
  parameter int PIXEL_WIDTH = 12,
  parameter int TILE_W      = 240,
  parameter int TILE_H      = 320,
  parameter int X0          = 50,
  parameter int Y0          = 26,
  parameter int X_PITCH     = 340,
  parameter int Y_PITCH     = 420,
  parameter int BORDER      = 4,
  parameter logic [PIXEL_WIDTH-1:0] HILITE = 12'hFF0,
  parameter int V_ACTIVE    = 720,
  localparam int SW = $clog2(NUM_TILES)
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          left_in,
  input  logic          right_in,
  input  logic          confirm_in,
  filter_tile_grid_if.slave vid,
  output logic [SW-1:0] select_out,
  output logic          locked_out
);
  localparam int XW = $clog2(TILE_W);
  localparam int YW = $clog2(TILE_H);

  typedef enum logic {BROWSE, LOCKED} state_t;

  function automatic int col_x(int k);
    return X0 + (k % COLS) * X_PITCH;
  endfunction

  function automatic int row_y(int k);
    return Y0 + (k / COLS) * Y_PITCH;
  endfunction

  function automatic logic in_rng(int p, int lo, int len);
    return (p >= lo) && (p < lo + len);
  endfunction

  logic l_q, r_q, c_q, arm_q;
  logic lp, rp, cp, commit;
  logic mv_up, mv_dn, force_p;
  logic [SW-1:0] pend_q, pend_d, sel_q, sel_d;
  state_t state_q, state_d;

  // arm_q swallows the first edge so a button held through reset is not a press
  assign lp = arm_q & left_in & ~l_q;
  assign rp = arm_q & right_in & ~r_q;
  assign cp = arm_q & confirm_in & ~c_q;

  assign commit = (vid.hcount_in == 11'd0) &&
                  (int'(vid.vcount_in) == V_ACTIVE);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      l_q   <= 1'b0;
      r_q   <= 1'b0;
      c_q   <= 1'b0;
      arm_q <= 1'b0;
    end else begin
      l_q   <= left_in;
      r_q   <= right_in;
      c_q   <= confirm_in;
      arm_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= BROWSE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BROWSE: if (cp) state_d = LOCKED;
      LOCKED: if (cp) state_d = BROWSE;
      default: state_d = BROWSE;
    endcase
  end

  always_comb begin
    locked_out = (state_q == LOCKED);
  end

  assign force_p = (state_q == BROWSE) & cp;
  assign mv_up   = (state_q == BROWSE) & ~cp & rp & ~lp;
  assign mv_dn   = (state_q == BROWSE) & ~cp & lp & ~rp;

  always_comb begin
    pend_d = pend_q;
    unique case (1'b1)
      force_p: pend_d = commit ? pend_q : sel_q;
      mv_up:   pend_d = (pend_q == SW'(NUM_TILES - 1)) ?
                        '0 : pend_q + 1'b1;
      mv_dn:   pend_d = (pend_q == '0) ?
                        SW'(NUM_TILES - 1) : pend_q - 1'b1;
      default: pend_d = pend_q;
    endcase
    sel_d = commit ? pend_q : sel_q;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pend_q <= '0;
      sel_q  <= '0;
    end else begin
      pend_q <= pend_d;
      sel_q  <= sel_d;
    end
  end

  assign select_out = sel_q;

  logic          hit1_d, hit1_q, brd1_d, brd1_q;
  logic [SW-1:0] idx1_d, idx1_q;
  logic [XW-1:0] tx_d, tx_q;
  logic [YW-1:0] ty_d, ty_q;

  always_comb begin
    hit1_d = 1'b0;
    brd1_d = 1'b0;
    idx1_d = '0;
    tx_d   = '0;
    ty_d   = '0;
    for (int k = 0; k < NUM_TILES; k++) begin
      if (in_rng(int'(vid.hcount_in), col_x(k), TILE_W) &&
          in_rng(int'(vid.vcount_in), row_y(k), TILE_H)) begin
        hit1_d = 1'b1;
        idx1_d = SW'(k);
        tx_d   = XW'(int'(vid.hcount_in) - col_x(k));
        ty_d   = YW'(int'(vid.vcount_in) - row_y(k));
      end else if ((sel_q == SW'(k)) &&
          in_rng(int'(vid.hcount_in), col_x(k) - BORDER,
                 TILE_W + 2 * BORDER) &&
          in_rng(int'(vid.vcount_in), row_y(k) - BORDER,
                 TILE_H + 2 * BORDER)) begin
        brd1_d = 1'b1;
      end
    end
  end

  logic          hit2_q, brd2_q;
  logic [SW-1:0] idx2_q;
  logic [PIXEL_WIDTH-1:0] chan, px_d, px_q;

  always_comb begin
    chan = '0;
    for (int k = 0; k < NUM_TILES; k++) begin
      if (idx2_q == SW'(k))
        chan = vid.tile_pixel_in[k*PIXEL_WIDTH +: PIXEL_WIDTH];
    end
    px_d = hit2_q ? chan : (brd2_q ? HILITE : '0);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hit1_q <= 1'b0;
      brd1_q <= 1'b0;
      idx1_q <= '0;
      tx_q   <= '0;
      ty_q   <= '0;
      hit2_q <= 1'b0;
      brd2_q <= 1'b0;
      idx2_q <= '0;
      px_q   <= '0;
    end else begin
      hit1_q <= hit1_d;
      brd1_q <= brd1_d;
      idx1_q <= idx1_d;
      tx_q   <= tx_d;
      ty_q   <= ty_d;
      hit2_q <= hit1_q;
      brd2_q <= brd1_q;
      idx2_q <= idx1_q;
      px_q   <= px_d;
    end
  end

  assign vid.tile_hit_out = hit1_q;
  assign vid.tile_x_out   = tx_q;
  assign vid.tile_y_out   = ty_q;
  assign vid.pixel_out    = px_q;
endmodule

// File: tb/tb_filter_tile_grid.sv
// Randomised and directed checks of filter_tile_grid against a
// geometry/selection reference model.
module tb_filter_tile_grid;
  localparam int NT = 6, COLS = 3, PW = 12;
  localparam int TW = 240, TH = 320;
  localparam int X0 = 50, Y0 = 26, XP = 340, YP = 420;
  localparam int BD = 4, VA = 720;
  localparam logic [11:0] HI = 12'hFF0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic left_i = 1'b0, right_i = 1'b0, conf_i = 1'b0;
  logic [2:0] sel_o;
  logic locked_o;

  filter_tile_grid_if #(.NUM_TILES(NT), .PIXEL_WIDTH(PW),
                        .TILE_W(TW), .TILE_H(TH)) vid ();

  filter_tile_grid dut (
    .clk_in     (clk),
    .rst_n_in   (rst_n),
    .left_in    (left_i),
    .right_in   (right_i),
    .confirm_in (conf_i),
    .vid        (vid.slave),
    .select_out (sel_o),
    .locked_out (locked_o)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] mem_f(int k, int x, int y);
    int v;
    v = k * 397 + x * 7 + y * 13 + 1;
    return v[11:0];
  endfunction

  // tile memories: one cycle of read latency
  always @(posedge clk) begin
    for (int k = 0; k < NT; k++)
      vid.tile_pixel_in[k*PW +: PW] <=
        mem_f(k, int'(vid.tile_x_out), int'(vid.tile_y_out));
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  int m_sel, m_pend;
  bit m_lock, m_arm, m_pl, m_pr, m_pc;
  logic [11:0] pq[$];

  task automatic model_reset();
    m_sel = 0; m_pend = 0; m_lock = 0;
    m_arm = 0; m_pl = 0; m_pr = 0; m_pc = 0;
    pq.delete();
  endtask

  task automatic model_edge(int h, int v, bit l, bit r, bit c);
    bit lp, rp, cp, com;
    int nsel;
    lp = l && !m_pl && m_arm;
    rp = r && !m_pr && m_arm;
    cp = c && !m_pc && m_arm;
    com = (h == 0) && (v == VA);
    nsel = com ? m_pend : m_sel;
    if (m_lock) begin
      if (cp) m_lock = 0;
    end else if (cp) begin
      m_lock = 1;
      if (!com) m_pend = m_sel;
    end else if (rp && !lp) m_pend = (m_pend + 1) % NT;
    else if (lp && !rp) m_pend = (m_pend + NT - 1) % NT;
    m_sel = nsel;
    m_pl = l; m_pr = r; m_pc = c; m_arm = 1;
  endtask

  function automatic bit inr(int p, int lo, int len);
    return p >= lo && p < lo + len;
  endfunction

  task automatic geom(input int h, input int v, input int sel,
                      output bit hit, output int tx, output int ty,
                      output logic [11:0] px);
    int xl, yt;
    hit = 0; tx = 0; ty = 0; px = 12'h0;
    for (int k = 0; k < NT; k++) begin
      xl = X0 + (k % COLS) * XP;
      yt = Y0 + (k / COLS) * YP;
      if (inr(h, xl, TW) && inr(v, yt, TH)) begin
        hit = 1; tx = h - xl; ty = v - yt;
        px = mem_f(k, tx, ty);
      end
    end
    if (!hit) begin
      xl = X0 + (sel % COLS) * XP;
      yt = Y0 + (sel / COLS) * YP;
      if (inr(h, xl - BD, TW + 2*BD) && inr(v, yt - BD, TH + 2*BD))
        px = HI;
    end
  endtask

  task automatic step(int h, int v, bit l, bit r, bit c);
    bit hit;
    int tx, ty;
    logic [11:0] px;
    vid.hcount_in = h[10:0];
    vid.vcount_in = v[9:0];
    left_i = l; right_i = r; conf_i = c;
    geom(h, v, m_sel, hit, tx, ty, px);
    @(posedge clk); #1;
    model_edge(h, v, l, r, c);
    chk("tile_hit", 32'(vid.tile_hit_out), 32'(hit));
    chk("tile_x", 32'(vid.tile_x_out), 32'(tx));
    chk("tile_y", 32'(vid.tile_y_out), 32'(ty));
    pq.push_back(px);
    if (pq.size() == 3) chk("pixel", 32'(vid.pixel_out), 32'(pq.pop_front()));
    chk("select", 32'(sel_o), 32'(m_sel));
    chk("locked", 32'(locked_o), 32'(m_lock));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 1100), $urandom_range(0, 719), 0, 0, 0);
  endtask

  task automatic press(bit l, bit r, bit c);
    step($urandom_range(0, 1100), $urandom_range(0, 719), l, r, c);
    step($urandom_range(0, 1100), $urandom_range(0, 719), 0, 0, 0);
  endtask

  task automatic commit();
    step(0, VA, 0, 0, 0);
    idle(3);
  endtask

  task automatic do_reset(bit hold_r);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_pixel", 32'(vid.pixel_out), 0);
    chk("rst_select", 32'(sel_o), 0);
    chk("rst_locked", 32'(locked_o), 0);
    chk("rst_hit", 32'(vid.tile_hit_out), 0);
    chk("rst_tx", 32'(vid.tile_x_out), 0);
    chk("rst_ty", 32'(vid.tile_y_out), 0);
    model_reset();
    left_i = 0; conf_i = 0; right_i = hold_r;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit l, r, c;
    int h, v;
    model_reset();
    vid.hcount_in = '0;
    vid.vcount_in = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    step(60, 30, 0, 0, 0);
    step(300, 30, 0, 0, 0);
    idle(4);
    for (int i = 0; i < 3; i++) step(60 + i, 30, 0, 0, 0);
    do_reset(1'b1);
    step(60, 30, 0, 1, 0);
    step(61, 30, 0, 0, 0);
    commit();

    for (int i = 0; i < 6; i++) press(0, 1, 0);
    commit();
    press(1, 0, 0);
    idle(2);
    commit();
    press(1, 0, 0);
    commit();
    step(388, 500, 0, 0, 0);
    step(388, 100, 0, 0, 0);
    step(390, 446, 0, 0, 0);
    idle(3);

    press(1, 1, 0);
    commit();
    step(0, VA, 0, 1, 0);
    step(5, 5, 0, 0, 0);
    commit();

    press(0, 0, 1);
    for (int i = 0; i < 3; i++) press(0, 1, 0);
    commit();
    press(0, 0, 1);
    press(0, 1, 0);
    commit();

    l = 0; r = 0; c = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset(r);
      if ($urandom_range(0, 7) == 0) l = ~l;
      if ($urandom_range(0, 7) == 0) r = ~r;
      if ($urandom_range(0, 31) == 0) c = ~c;
      if ($urandom_range(0, 39) == 0) begin
        h = 0; v = VA;
      end else begin
        h = $urandom_range(0, 1100);
        v = $urandom_range(0, 739);
      end
      step(h, v, l, r, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
